// File: rtl/character_sprite_renderer.sv
// character_sprite_renderer
//   Converts the latched character display id and position into synchronous
//   sprite ROM fetches during the VGA scan. It then returns a transparency-masked
//   sprite pixel three cycles after each scan pixel.
//   Optional build macro: CHAR_MIRROR_EN. When it is defined, a left-facing
//   character reads its ROM image with the columns mirrored.
module character_sprite_renderer #(
    parameter int                     SCREEN_X_WIDTH    = 10,
    parameter int                     SCREEN_Y_WIDTH    = 10,
    parameter int                     SPRITE_SIZE_LOG2  = 5,
    parameter int                     COLOR_WIDTH       = 12,
    parameter logic [COLOR_WIDTH-1:0] TRANSPARENT_COLOR = 12'hF0F,
    localparam int                    ROM_ADDR_WIDTH    = 3 + 2*SPRITE_SIZE_LOG2
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      frame_start,
    input  logic                      pix_valid,
    input  logic [SCREEN_X_WIDTH-1:0] pix_x,
    input  logic [SCREEN_Y_WIDTH-1:0] pix_y,
    input  logic [SCREEN_X_WIDTH-1:0] char_x,
    input  logic [SCREEN_Y_WIDTH-1:0] char_y,
    input  logic [2:0]                char_display_id,
    input  logic                      char_facing_left,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic [COLOR_WIDTH-1:0]    rom_data,
    output logic [COLOR_WIDTH-1:0]    sprite_pixel,
    output logic                      sprite_hit,
    output logic                      out_valid
);

    localparam int SPRITE_SIDE = 1 << SPRITE_SIZE_LOG2;

    // Frame shadow copies of the character state
    logic [2:0]                id_s_q;
    logic [SCREEN_X_WIDTH-1:0] x_s_q;
    logic [SCREEN_Y_WIDTH-1:0] y_s_q;

    // Pipeline state
    logic [ROM_ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic                      v1_q, h1_q, v2_q, h2_q;
    logic [COLOR_WIDTH-1:0]    sprite_pixel_q, sprite_pixel_d;
    logic                      sprite_hit_q, sprite_hit_d;
    logic                      out_valid_q;

    // Stage-1 combinational terms
    logic [SCREEN_X_WIDTH:0]     x_end;
    logic [SCREEN_Y_WIDTH:0]     y_end;
    logic                        in_box;
    logic [SPRITE_SIZE_LOG2-1:0] col, row, col_eff;

    // Latch id/position on frame_start so a sprite never changes mid-frame
    // NOTE: every register here uses <= so all flops sample pre-edge values.
    // That is why a pixel that shares a cycle with frame_start still sees the old shadow.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            id_s_q <= 3'd0;
            x_s_q  <= '0;
            y_s_q  <= '0;
        end else if (frame_start) begin
            // Id 7 is not a valid display id, so treat it as IDLE_DIS_1.
            id_s_q <= (char_display_id == 3'd7) ? 3'd0 : char_display_id;
            x_s_q  <= char_x;
            y_s_q  <= char_y;
        end
    end

`ifdef CHAR_MIRROR_EN
    logic face_s_q;

    // Latch facing with the rest of the frame shadow
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            face_s_q <= 1'b0;
        end else if (frame_start) begin
            face_s_q <= char_facing_left;
        end
    end

    // (SIDE-1) - col is the bitwise inverse of col for a power-of-two side
    assign col_eff = face_s_q ? ~col : col;
`else
    logic unused_facing;
    assign unused_facing = char_facing_left;
    assign col_eff       = col;
`endif

    // The box end is computed one bit wider, so a sprite at the right or bottom edge never wraps to column/row 0
    assign x_end  = {1'b0, x_s_q} + (SCREEN_X_WIDTH+1)'(SPRITE_SIDE);
    assign y_end  = {1'b0, y_s_q} + (SCREEN_Y_WIDTH+1)'(SPRITE_SIDE);
    assign in_box = pix_valid
                  && (pix_x >= x_s_q) && ({1'b0, pix_x} < x_end)
                  && (pix_y >= y_s_q) && ({1'b0, pix_y} < y_end);

    // Only the low bits of the offset matter, and the subtraction wraps modulo the sprite side
    assign col = pix_x[SPRITE_SIZE_LOG2-1:0] - x_s_q[SPRITE_SIZE_LOG2-1:0];
    assign row = pix_y[SPRITE_SIZE_LOG2-1:0] - y_s_q[SPRITE_SIZE_LOG2-1:0];

    // Next ROM address and the registered output terms of stage 3
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        rom_addr_d     = rom_addr_q;
        sprite_hit_d   = 1'b0;
        sprite_pixel_d = '0;
        if (in_box) begin
            rom_addr_d = {id_s_q, row, col_eff};
        end
        if (v2_q && h2_q && (rom_data != TRANSPARENT_COLOR)) begin
            sprite_hit_d   = 1'b1;
            sprite_pixel_d = rom_data;
        end
    end

    // Three-stage pixel pipeline: address, ROM read, masked output
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rom_addr_q     <= '0;
            v1_q           <= 1'b0;
            h1_q           <= 1'b0;
            v2_q           <= 1'b0;
            h2_q           <= 1'b0;
            out_valid_q    <= 1'b0;
            sprite_hit_q   <= 1'b0;
            sprite_pixel_q <= '0;
        end else begin
            rom_addr_q     <= rom_addr_d;
            v1_q           <= pix_valid;
            h1_q           <= in_box;
            v2_q           <= v1_q;
            h2_q           <= h1_q;
            out_valid_q    <= v2_q;
            sprite_hit_q   <= sprite_hit_d;
            sprite_pixel_q <= sprite_pixel_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign sprite_pixel = sprite_pixel_q;
    assign sprite_hit   = sprite_hit_q;
    assign out_valid    = out_valid_q;

endmodule

// File: tb/tb_character_sprite_renderer.sv
// Directed testbench for character_sprite_renderer.
// The bench drives rom_data directly as a constant per scenario. The pipeline's
// address/mask/latency behaviour is checked against hand-computed values.
module tb_character_sprite_renderer;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        frame_start;
    logic        pix_valid;
    logic [9:0]  pix_x, pix_y, char_x, char_y;
    logic [2:0]  char_display_id;
    logic        char_facing_left;
    logic [12:0] rom_addr;
    logic [11:0] rom_data;
    logic [11:0] sprite_pixel;
    logic        sprite_hit;
    logic        out_valid;

    int tests_run    = 0;
    int tests_failed = 0;

    character_sprite_renderer dut (
        .sys_clk          (sys_clk),
        .sys_rst          (sys_rst),
        .frame_start      (frame_start),
        .pix_valid        (pix_valid),
        .pix_x            (pix_x),
        .pix_y            (pix_y),
        .char_x           (char_x),
        .char_y           (char_y),
        .char_display_id  (char_display_id),
        .char_facing_left (char_facing_left),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .sprite_pixel     (sprite_pixel),
        .sprite_hit       (sprite_hit),
        .out_valid        (out_valid)
    );

    always #5 sys_clk = ~sys_clk;

    // Advance one clock and settle past the edge before sampling or driving
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive_pix(input logic [9:0] x, input logic [9:0] y, input logic v);
        pix_x     = x;
        pix_y     = y;
        pix_valid = v;
        tick();
    endtask

    task automatic load_frame(input logic [2:0] id, input logic [9:0] cx,
                              input logic [9:0] cy, input logic face);
        char_display_id  = id;
        char_x           = cx;
        char_y           = cy;
        char_facing_left = face;
        frame_start      = 1'b1;
        pix_valid        = 1'b0;
        tick();
        frame_start      = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst   = 1'b1;
        rom_data  = 12'h123;
        pix_valid = 1'b1;
        pix_x     = 10'd0;
        pix_y     = 10'd0;
        repeat (3) tick();
        tests_run++;
        if (rom_addr !== 13'h0000) begin
            $display("FAIL reset_rom_addr got %h want %h", rom_addr, 13'h0000);
            tests_failed++;
        end
        tests_run++;
        if (sprite_pixel !== 12'h000) begin
            $display("FAIL reset_sprite_pixel got %h want %h", sprite_pixel, 12'h000);
            tests_failed++;
        end
        tests_run++;
        if (sprite_hit !== 1'b0) begin
            $display("FAIL reset_sprite_hit got %b want 0", sprite_hit);
            tests_failed++;
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            $display("FAIL reset_out_valid got %b want 0", out_valid);
            tests_failed++;
        end
    endtask

    // Shadow is (0,0) after reset, so pixel (0,0) lies inside the sprite box
    task automatic test_latency_after_reset();
        sys_rst   = 1'b0;
        pix_valid = 1'b0;
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            $display("FAIL blank_out_valid got %b want 0", out_valid);
            tests_failed++;
        end
        drive_pix(10'd0, 10'd0, 1'b1);
        tests_run++;
        if (out_valid !== 1'b0) begin
            $display("FAIL lat_cycle1_out_valid got %b want 0", out_valid);
            tests_failed++;
        end
        drive_pix(10'd0, 10'd0, 1'b0);
        tests_run++;
        if (out_valid !== 1'b0) begin
            $display("FAIL lat_cycle2_out_valid got %b want 0", out_valid);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || sprite_hit !== 1'b1 || sprite_pixel !== 12'h123) begin
            $display("FAIL lat_cycle3 got v=%b hit=%b pix=%h want v=1 hit=1 pix=123",
                     out_valid, sprite_hit, sprite_pixel);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || sprite_hit !== 1'b0) begin
            $display("FAIL blank_no_hit got v=%b hit=%b want v=0 hit=0", out_valid, sprite_hit);
            tests_failed++;
        end
    endtask

    task automatic test_box_addressing();
        rom_data = 12'h123;
        load_frame(3'd3, 10'd100, 10'd50, 1'b0);
        drive_pix(10'd100, 10'd50, 1'b1);
        tests_run++;
        if (rom_addr !== 13'h0C00) begin
            $display("FAIL addr_top_left got %h want %h", rom_addr, 13'h0C00);
            tests_failed++;
        end
        drive_pix(10'd131, 10'd81, 1'b1);
        tests_run++;
        if (rom_addr !== 13'h0FFF) begin
            $display("FAIL addr_bottom_right got %h want %h", rom_addr, 13'h0FFF);
            tests_failed++;
        end
        drive_pix(10'd132, 10'd81, 1'b1);
        tests_run++;
        if (rom_addr !== 13'h0FFF) begin
            $display("FAIL addr_hold_outside got %h want %h", rom_addr, 13'h0FFF);
            tests_failed++;
        end
        tests_run++;
        if (sprite_hit !== 1'b1 || sprite_pixel !== 12'h123) begin
            $display("FAIL hit_top_left got hit=%b pix=%h want hit=1 pix=123", sprite_hit, sprite_pixel);
            tests_failed++;
        end
        drive_pix(10'd0, 10'd0, 1'b0);
        tests_run++;
        if (sprite_hit !== 1'b1) begin
            $display("FAIL hit_bottom_right got %b want 1", sprite_hit);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || sprite_hit !== 1'b0 || sprite_pixel !== 12'h000) begin
            $display("FAIL miss_col132 got v=%b hit=%b pix=%h want v=1 hit=0 pix=000",
                     out_valid, sprite_hit, sprite_pixel);
            tests_failed++;
        end
        repeat (2) tick();
    endtask

    task automatic test_transparency();
        rom_data = 12'hF0F;
        drive_pix(10'd110, 10'd60, 1'b1);
        drive_pix(10'd0, 10'd0, 1'b0);
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || sprite_hit !== 1'b0 || sprite_pixel !== 12'h000) begin
            $display("FAIL transparent got v=%b hit=%b pix=%h want v=1 hit=0 pix=000",
                     out_valid, sprite_hit, sprite_pixel);
            tests_failed++;
        end
        rom_data = 12'h123;
        repeat (2) tick();
    endtask

    task automatic test_opaque_latency();
        drive_pix(10'd105, 10'd55, 1'b1);
        tests_run++;
        if (sprite_hit !== 1'b0) begin
            $display("FAIL opaque_early1 got %b want 0", sprite_hit);
            tests_failed++;
        end
        drive_pix(10'd0, 10'd0, 1'b0);
        tests_run++;
        if (sprite_hit !== 1'b0) begin
            $display("FAIL opaque_early2 got %b want 0", sprite_hit);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (sprite_hit !== 1'b1 || sprite_pixel !== 12'h123) begin
            $display("FAIL opaque_cycle3 got hit=%b pix=%h want hit=1 pix=123", sprite_hit, sprite_pixel);
            tests_failed++;
        end
        repeat (2) tick();
    endtask

    task automatic test_frame_latch();
        char_display_id = 3'd5;
        drive_pix(10'd100, 10'd50, 1'b1);
        tests_run++;
        if (rom_addr[12:10] !== 3'b011) begin
            $display("FAIL id_midframe got %b want 011", rom_addr[12:10]);
            tests_failed++;
        end
        load_frame(3'd5, 10'd100, 10'd50, 1'b0);
        drive_pix(10'd100, 10'd50, 1'b1);
        tests_run++;
        if (rom_addr[12:10] !== 3'b101) begin
            $display("FAIL id_after_frame got %b want 101", rom_addr[12:10]);
            tests_failed++;
        end
        // frame_start together with a pixel: that pixel still sees id 5
        char_display_id = 3'd7;
        frame_start     = 1'b1;
        drive_pix(10'd100, 10'd50, 1'b1);
        frame_start     = 1'b0;
        tests_run++;
        if (rom_addr[12:10] !== 3'b101) begin
            $display("FAIL id_same_cycle got %b want 101", rom_addr[12:10]);
            tests_failed++;
        end
        drive_pix(10'd101, 10'd50, 1'b1);
        tests_run++;
        if (rom_addr !== 13'h0001) begin
            $display("FAIL id7_sanitised got %h want %h", rom_addr, 13'h0001);
            tests_failed++;
        end
        drive_pix(10'd0, 10'd0, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_right_edge();
        load_frame(3'd0, 10'd1000, 10'd0, 1'b0);
        drive_pix(10'd1023, 10'd0, 1'b1);
        tests_run++;
        if (rom_addr !== 13'h0017) begin
            $display("FAIL edge_addr got %h want %h", rom_addr, 13'h0017);
            tests_failed++;
        end
        drive_pix(10'd0, 10'd0, 1'b1);
        tests_run++;
        if (rom_addr !== 13'h0017) begin
            $display("FAIL edge_wrap_addr got %h want %h", rom_addr, 13'h0017);
            tests_failed++;
        end
        drive_pix(10'd0, 10'd0, 1'b0);
        tests_run++;
        if (sprite_hit !== 1'b1) begin
            $display("FAIL edge_col1023_hit got %b want 1", sprite_hit);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || sprite_hit !== 1'b0) begin
            $display("FAIL edge_nowrap got v=%b hit=%b want v=1 hit=0", out_valid, sprite_hit);
            tests_failed++;
        end
        repeat (2) tick();
    endtask

    task automatic test_mirror();
        logic [4:0] exp_col;
`ifdef CHAR_MIRROR_EN
        exp_col = 5'd31;
`else
        exp_col = 5'd0;
`endif
        load_frame(3'd0, 10'd0, 10'd0, 1'b1);
        drive_pix(10'd0, 10'd0, 1'b1);
        tests_run++;
        if (rom_addr[4:0] !== exp_col) begin
            $display("FAIL mirror_col got %0d want %0d", rom_addr[4:0], exp_col);
            tests_failed++;
        end
        tests_run++;
        if (rom_addr[9:5] !== 5'd0) begin
            $display("FAIL mirror_row got %0d want 0", rom_addr[9:5]);
            tests_failed++;
        end
        char_facing_left = 1'b0;
        drive_pix(10'd0, 10'd0, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_mid_reset();
        load_frame(3'd3, 10'd100, 10'd50, 1'b0);
        drive_pix(10'd100, 10'd50, 1'b1);
        drive_pix(10'd101, 10'd50, 1'b1);
        sys_rst = 1'b1;
        drive_pix(10'd102, 10'd50, 1'b1);
        tests_run++;
        if (rom_addr !== 13'h0000 || out_valid !== 1'b0 || sprite_hit !== 1'b0) begin
            $display("FAIL mid_reset got addr=%h v=%b hit=%b want addr=0000 v=0 hit=0",
                     rom_addr, out_valid, sprite_hit);
            tests_failed++;
        end
        sys_rst = 1'b0;
        pix_valid = 1'b0;
        tick();
    endtask

    initial begin
        sys_rst          = 1'b1;
        frame_start      = 1'b0;
        pix_valid        = 1'b0;
        pix_x            = '0;
        pix_y            = '0;
        char_x           = '0;
        char_y           = '0;
        char_display_id  = 3'd0;
        char_facing_left = 1'b0;
        rom_data         = 12'h123;

        test_reset();
        test_latency_after_reset();
        test_box_addressing();
        test_transparency();
        test_opaque_latency();
        test_frame_latch();
        test_right_edge();
        test_mirror();
        test_mid_reset();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
